// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default reset PC / halt opcode, NOP encoding and a saturating counter helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [3:0]  HLT_OPC_DEF  = 4'hF;
  localparam logic [15:0] NOP_INSTR    = 16'h0000;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with flush > hold > load priority and synchronous
// active-low reset to a NOP bubble.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [15:0] d_instr,
  input  logic [15:0] d_pc_plus1,
  output logic [15:0] q_instr,
  output logic [15:0] q_pc_plus1,
  output logic        q_valid
);

  logic [15:0] instr_r;
  logic [15:0] pc_plus1_r;
  logic        valid_r;

  // IF/ID storage; a flush only kills validity, the data is left as-is
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_r    <= NOP_INSTR;
      pc_plus1_r <= 16'h0000;
      valid_r    <= 1'b0;
    end else if (flush) begin
      instr_r    <= instr_r;
      pc_plus1_r <= pc_plus1_r;
      valid_r    <= 1'b0;
    end else if (hold) begin
      instr_r    <= instr_r;
      pc_plus1_r <= pc_plus1_r;
      valid_r    <= valid_r;
    end else if (load) begin
      instr_r    <= d_instr;
      pc_plus1_r <= d_pc_plus1;
      valid_r    <= 1'b1;
    end else begin
      instr_r    <= instr_r;
      pc_plus1_r <= pc_plus1_r;
      valid_r    <= valid_r;
    end
  end

  assign q_instr    = instr_r;
  assign q_pc_plus1 = pc_plus1_r;
  assign q_valid    = valid_r;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT control FSM and IF/ID
// register. Optional performance counters are built when IF_PERF_CNT_EN is defined.
module pc_fetch
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter logic [3:0]  HLT_OPC  = HLT_OPC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_tgt,
  input  logic [15:0] instr,
  output logic [15:0] addr,
  output logic        rd_en,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  fetch_state_t state_r;
  fetch_state_t next_state_s;
  logic [15:0]  pc_r;
  logic [15:0]  pc_next_s;
  logic [15:0]  pc_plus1_s;
  logic         hlt_s;
  logic         load_s;
  logic         flush_s;
  logic         hold_s;
  logic         halted_r;

  assign pc_plus1_s = pc_r + 16'd1;
  assign hlt_s      = (instr[15:12] == HLT_OPC);
  assign addr       = pc_r;
  assign halted     = halted_r;

  // State, PC and halted flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      pc_r     <= pc_next_s;
      halted_r <= (next_state_s == ST_HALT);
    end
  end

  // Next-state logic; a redirect always wins over stall and halt
  always_comb begin
    next_state_s = state_r;
    if (branch_taken) begin
      next_state_s = ST_RUN;
    end else begin
      case (state_r)
        ST_IDLE: next_state_s = ST_RUN;
        ST_RUN: begin
          if (stall) begin
            next_state_s = ST_RUN;
          end else if (hlt_s) begin
            next_state_s = ST_HALT;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_HALT: next_state_s = ST_HALT;
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // Output / datapath control decode
  always_comb begin
    rd_en     = (state_r == ST_RUN);
    pc_next_s = pc_r;
    load_s    = 1'b0;
    flush_s   = 1'b0;
    hold_s    = stall & ~branch_taken;
    if (branch_taken) begin
      pc_next_s = branch_tgt;
      flush_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: flush_s = 1'b1;
        ST_RUN: begin
          if (stall) begin
            load_s = 1'b0;
          end else if (hlt_s) begin
            // HLT is handed to decode but the PC stays on it
            load_s = 1'b1;
          end else begin
            load_s    = 1'b1;
            pc_next_s = pc_plus1_s;
          end
        end
        ST_HALT: flush_s = ~stall;
        default: flush_s = 1'b1;
      endcase
    end
  end

  ifid_reg u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_s),
    .flush      (flush_s),
    .hold       (hold_s),
    .d_instr    (instr),
    .d_pc_plus1 (pc_plus1_s),
    .q_instr    (ifid_instr),
    .q_pc_plus1 (ifid_pc_plus1),
    .q_valid    (ifid_valid)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;

  // Saturating performance counters, counted only while running
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_r <= 32'h0000_0000;
      stall_cnt_r <= 32'h0000_0000;
    end else begin
      if ((state_r == ST_RUN) && load_s) begin
        fetch_cnt_r <= sat_inc32(fetch_cnt_r);
      end else begin
        fetch_cnt_r <= fetch_cnt_r;
      end
      if ((state_r == ST_RUN) && stall && !branch_taken) begin
        stall_cnt_r <= sat_inc32(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_r;
  assign stall_cnt = stall_cnt_r;
`else
  assign fetch_cnt = 32'h0000_0000;
  assign stall_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a small instruction memory model drives instr,
// expected IF/ID captures are queued at drive time and popped after each edge.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_tgt;
  logic [15:0] instr;
  logic [15:0] addr;
  logic        rd_en;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] pc1;
    logic        vld;
  } ifid_exp_t;

  ifid_exp_t   sb_q[$];
  logic [15:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_fetch = 32'd0;
  logic [31:0] exp_stall = 32'd0;

  pc_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_tgt    (branch_tgt),
    .instr         (instr),
    .addr          (addr),
    .rd_en         (rd_en),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Low 256 words come from the table, the rest return a fixed non-HLT pattern
  assign instr = (addr < 16'd256) ? mem[addr[7:0]] : {4'h3, addr[11:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cap(input logic [15:0] ins, input logic [15:0] pc1);
    ifid_exp_t e;
    e.ins = ins;
    e.pc1 = pc1;
    e.vld = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    ifid_exp_t e;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_instr"}, {16'h0, ifid_instr}, {16'h0, e.ins});
      chk({tag, "_pc1"}, {16'h0, ifid_pc_plus1}, {16'h0, e.pc1});
      chk({tag, "_valid"}, {31'h0, ifid_valid}, {31'h0, e.vld});
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef IF_PERF_CNT_EN
    chk({tag, "_fcnt"}, fetch_cnt, exp_fetch);
    chk({tag, "_scnt"}, stall_cnt, exp_stall);
`else
    chk({tag, "_fcnt"}, fetch_cnt, 32'h0);
    chk({tag, "_scnt"}, stall_cnt, 32'h0);
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, {16'h0, addr}, 32'h0000);
    chk({tag, "_rden"}, {31'h0, rd_en}, 32'h0);
    chk({tag, "_instr"}, {16'h0, ifid_instr}, 32'h0000);
    chk({tag, "_pc1"}, {16'h0, ifid_pc_plus1}, 32'h0000);
    chk({tag, "_valid"}, {31'h0, ifid_valid}, 32'h0);
    chk({tag, "_halt"}, {31'h0, halted}, 32'h0);
    chk_cnt(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[7] = 16'hF000;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_tgt = 16'h0000;
    tick(); tick();
    chk_reset("reset");

    // Release: one IDLE cycle with rd_en low, then RUN from address 0
    rst_n = 1'b1;
    chk("idle_rden", {31'h0, rd_en}, 32'h0);
    tick();
    chk("run_rden", {31'h0, rd_en}, 32'h1);
    chk("run_addr0", {16'h0, addr}, 32'h0);
    chk("run_novalid", {31'h0, ifid_valid}, 32'h0);
    for (int p = 0; p < 5; p++) begin
      push_cap(mem[p], 16'(p + 1));
      exp_fetch++;
      tick();
      pop_chk($sformatf("adv%0d", p));
    end
    chk("at5_addr", {16'h0, addr}, 32'h5);
    chk_cnt("at5");

    // Three-cycle stall at PC 5
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      exp_stall++;
      chk($sformatf("stall%0d_addr", s), {16'h0, addr}, 32'h5);
      chk($sformatf("stall%0d_instr", s), {16'h0, ifid_instr}, {16'h0, mem[4]});
      chk($sformatf("stall%0d_pc1", s), {16'h0, ifid_pc_plus1}, 32'h5);
      chk($sformatf("stall%0d_valid", s), {31'h0, ifid_valid}, 32'h1);
    end
    stall = 1'b0;
    chk_cnt("stall3");

    // Advance to 7, then hit HLT at 7
    for (int p = 5; p < 7; p++) begin
      push_cap(mem[p], 16'(p + 1));
      exp_fetch++;
      tick();
      pop_chk($sformatf("adv%0d", p));
    end
    push_cap(16'hF000, 16'h0008);
    exp_fetch++;
    tick();
    pop_chk("hlt");
    chk("hlt_addr", {16'h0, addr}, 32'h7);
    chk("hlt_halted", {31'h0, halted}, 32'h1);
    chk("hlt_rden", {31'h0, rd_en}, 32'h0);
    tick();
    chk("halt_novalid", {31'h0, ifid_valid}, 32'h0);
    chk("halt_addr", {16'h0, addr}, 32'h7);
    chk("halt_halted", {31'h0, halted}, 32'h1);
    chk_cnt("halt");

    // Branch out of HALT to 0x0010
    branch_taken = 1'b1; branch_tgt = 16'h0010;
    tick();
    branch_taken = 1'b0;
    chk("brh_addr", {16'h0, addr}, 32'h0010);
    chk("brh_valid", {31'h0, ifid_valid}, 32'h0);
    chk("brh_halted", {31'h0, halted}, 32'h0);
    chk("brh_rden", {31'h0, rd_en}, 32'h1);
    push_cap(mem[16], 16'h0011);
    exp_fetch++;
    tick();
    pop_chk("adv16");

    // Branch with simultaneous stall: branch wins, nothing counted as stall
    branch_taken = 1'b1; branch_tgt = 16'h0040; stall = 1'b1;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    chk("brst_addr", {16'h0, addr}, 32'h0040);
    chk("brst_valid", {31'h0, ifid_valid}, 32'h0);
    chk_cnt("brst");

    // PC wrap from 0xFFFF
    branch_taken = 1'b1; branch_tgt = 16'hFFFF;
    tick();
    branch_taken = 1'b0;
    chk("wrap_pre", {16'h0, addr}, 32'hFFFF);
    push_cap(16'h3FFF, 16'h0000);
    exp_fetch++;
    tick();
    pop_chk("wrap");
    chk("wrap_addr", {16'h0, addr}, 32'h0000);

    // Reach HALT again, then reset with branch and stall also asserted
    branch_taken = 1'b1; branch_tgt = 16'h0007;
    tick();
    branch_taken = 1'b0;
    exp_fetch++;
    tick();
    chk("halt2", {31'h0, halted}, 32'h1);
    rst_n = 1'b0; branch_taken = 1'b1; branch_tgt = 16'h0099; stall = 1'b1;
    exp_fetch = 32'd0; exp_stall = 32'd0;
    tick();
    rst_n = 1'b1; branch_taken = 1'b0; stall = 1'b0;
    chk_reset("rst_halt");
    tick();
    chk("rst_run_rden", {31'h0, rd_en}, 32'h1);
    chk("rst_run_addr", {16'h0, addr}, 32'h0);
    push_cap(16'h1111, 16'h0001);
    exp_fetch++;
    tick();
    pop_chk("rst_adv0");
    chk_cnt("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
